// File: rtl/gpr_file_pkg.sv
// gpr_file_pkg: shared register-file defines, types and debug FSM encoding.
`ifndef GPR_FILE_DEFINES
`define GPR_FILE_DEFINES
`define RegBus       31:0
`define RegAddrBus   4:0
`define ZeroWord     32'h0000_0000
`define ZeroReg      5'd0
`define WriteEnable  1'b1
`define WriteDisable 1'b0
`define RegNum       32
`define DbgIdle      1'b0
`define DbgAck       1'b1
`endif

package gpr_file_pkg;
    typedef logic [`RegBus]     word_t;
    typedef logic [`RegAddrBus] addr_t;
    typedef enum logic {DBG_IDLE = `DbgIdle, DBG_ACK = `DbgAck} dbg_state_t;
    localparam word_t ZERO_WORD = `ZeroWord;
    localparam addr_t ZERO_REG  = `ZeroReg;
endpackage

// File: rtl/gpr_file_rd_port.sv
// gpr_rd_port: x0 forcing and same-cycle write-through bypass for one read path.
module gpr_rd_port
    import gpr_file_pkg::*;
(
    input  logic  rst_i,
    input  addr_t raddr_i,
    input  logic  we_i,
    input  addr_t waddr_i,
    input  word_t wdata_i,
    input  word_t mem_rdata_i,
    output word_t rdata_o
);
    always_comb begin
        rdata_o = (rst_i || raddr_i == ZERO_REG) ? ZERO_WORD :
                  (we_i == `WriteEnable && raddr_i == waddr_i) ? wdata_i : mem_rdata_i;
    end
endmodule

// File: rtl/gpr_file.sv
// gpr_file: RV32 GPR file with two bypassed read ports and a request/ack debug port.
module gpr_file
    import gpr_file_pkg::*;
#(
    parameter int REG_NUM = `RegNum,
    parameter bit DBG_EN  = 1'b1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  we_i,
    input  addr_t waddr_i,
    input  word_t wdata_i,
    input  addr_t raddr1_i,
    output word_t rdata1_o,
    input  addr_t raddr2_i,
    output word_t rdata2_o,
    input  logic  dbg_req_i,
    input  logic  dbg_we_i,
    input  addr_t dbg_addr_i,
    input  word_t dbg_wdata_i,
    output logic  dbg_ack_o,
    output word_t dbg_rdata_o
);
    word_t      mem_q [REG_NUM];
    dbg_state_t state_q;
    logic       dbg_ack_q;
    word_t      dbg_rdata_q;
    word_t      dbg_rd;
    logic       dbg_go;
    logic       dbg_wr_ok;

    gpr_rd_port u_rd1 (.rst_i(rst), .raddr_i(raddr1_i), .we_i(we_i), .waddr_i(waddr_i),
                       .wdata_i(wdata_i), .mem_rdata_i(mem_q[raddr1_i]), .rdata_o(rdata1_o));
    gpr_rd_port u_rd2 (.rst_i(rst), .raddr_i(raddr2_i), .we_i(we_i), .waddr_i(waddr_i),
                       .wdata_i(wdata_i), .mem_rdata_i(mem_q[raddr2_i]), .rdata_o(rdata2_o));
    gpr_rd_port u_rdd (.rst_i(rst), .raddr_i(dbg_addr_i), .we_i(we_i), .waddr_i(waddr_i),
                       .wdata_i(wdata_i), .mem_rdata_i(mem_q[dbg_addr_i]), .rdata_o(dbg_rd));

    // A primary write to the same address takes precedence over the debug write.
    always_comb begin
        dbg_go    = DBG_EN && state_q == DBG_IDLE && dbg_req_i;
        dbg_wr_ok = dbg_go && dbg_we_i && dbg_addr_i != ZERO_REG &&
                    !(we_i == `WriteEnable && waddr_i == dbg_addr_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) mem_q[i] <= ZERO_WORD;
            state_q     <= DBG_IDLE;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= ZERO_WORD;
        end else begin
            if (dbg_wr_ok) mem_q[dbg_addr_i] <= dbg_wdata_i;
            if (we_i == `WriteEnable && waddr_i != ZERO_REG) mem_q[waddr_i] <= wdata_i;
            if (dbg_go && !dbg_we_i) dbg_rdata_q <= dbg_rd;
            state_q   <= dbg_go ? DBG_ACK : DBG_IDLE;
            dbg_ack_q <= dbg_go;
        end
    end

    assign dbg_ack_o   = dbg_ack_q;
    assign dbg_rdata_o = dbg_rdata_q;
endmodule

// File: doc/gpr_file.md
Name: gpr_file

Overview:
- General-purpose register file for the RV32 core, directly downstream of the post-writeback pipeline register.
- Consumes that register's write-data, write-enable and write-address triple.
- Serves two combinational operand read ports to decode, with write-through bypass.
- Adds a debug access port with a registered request/acknowledge handshake for the JTAG/debug module.

Parameters:
- REG_NUM, 32, number of architectural registers (x0..x31); address width fixed by `RegAddrBus.
- DBG_EN, 1, 1 = debug port active; 0 = debug inputs ignored, dbg_ack_o tied 0.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- we_i  input  1  write enable from post-writeback pipeline register
- waddr_i  input  5 (`RegAddrBus)  write address
- wdata_i  input  32 (`RegBus)  write data
- raddr1_i  input  5  read port 1 address
- rdata1_o  output  32  read port 1 data (combinational)
- raddr2_i  input  5  read port 2 address
- rdata2_o  output  32  read port 2 data (combinational)
- dbg_req_i  input  1  debug access request, level, held until ack
- dbg_we_i  input  1  1 = debug write, 0 = debug read
- dbg_addr_i  input  5  debug register address
- dbg_wdata_i  input  32  debug write data
- dbg_ack_o  output  1  one-cycle acknowledge pulse
- dbg_rdata_o  output  32  debug read data, valid while dbg_ack_o = 1

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset:
  - rst sampled high at posedge clears all REG_NUM entries to `ZeroWord and drives dbg_ack_o = 0 and dbg_rdata_o = `ZeroWord.
  - Debug FSM returns to IDLE.
  - rst overrides any write presented in the same cycle.
  - While rst = 1, rdata1_o and rdata2_o read 0.
- x0: writes to address 0 from either port are discarded; reads of address 0 always return 0, including during bypass.
- Primary write: when we_i = 1 and waddr_i != 0, mem[waddr_i] <= wdata_i at posedge. Latency 1 cycle.
- Read ports, combinational, evaluated in priority order:
  - raddr == 0 -> 0.
  - Else if we_i = 1 and raddr == waddr_i -> wdata_i (same-cycle bypass).
  - Else mem[raddr].
  - Both ports are independent; the same address on both ports is legal.
- Debug FSM states: IDLE, ACK.
  - IDLE, dbg_req_i = 1 -> perform access, go to ACK.
  - Debug write: commits mem[dbg_addr_i] <= dbg_wdata_i at that edge.
  - Debug read: captures dbg_rdata_o at that edge. The read uses the same bypass rule as the read ports, so it sees a same-cycle primary write.
  - ACK: dbg_ack_o = 1 for exactly one cycle, then IDLE.
  - A request still high in IDLE after ACK starts a new access; the requester must drop dbg_req_i on ack.
  - dbg_rdata_o holds its last value outside ACK; it is only defined while ack = 1.
- Simultaneous writes:
  - Primary and debug write to different nonzero addresses: both commit at the same edge.
  - Same address: the primary write wins, the debug write is dropped, and the debug access is still acknowledged.
- Debug write bypass: debug writes are not bypassed to the read ports; they become visible the cycle after commit.
- rst asserted in ACK: ack drops next cycle and the FSM returns to IDLE.
- DBG_EN = 0: FSM held in IDLE; no debug writes.

Decomposition:
- Shared defines.v supplies `RegBus, `RegAddrBus, `ZeroWord, `ZeroReg, `WriteEnable, `WriteDisable.
- Add to defines.v: `RegNum (32), and debug FSM state encodings `DbgIdle and `DbgAck.
- Sub-module gpr_rd_port: address compare, x0 and bypass mux. Instantiated three times: read port 1, read port 2, debug read.

Test Plan:
- Reset: write x5 = 0x1234_5678, assert rst for 1 cycle -> rdata1_o for raddr1_i = 5 reads 0x0000_0000; dbg_ack_o = 0.
- Write then read: we_i = 1, waddr_i = 3, wdata_i = 0xDEAD_BEEF at cycle N -> raddr1_i = 3 at N+1 reads 0xDEAD_BEEF.
- Bypass: same cycle as the write (we_i = 1, waddr_i = 7, wdata_i = 0xA5A5_0001), raddr2_i = 7 -> rdata2_o = 0xA5A5_0001 combinationally.
- x0: we_i = 1, waddr_i = 0, wdata_i = 0xFFFF_FFFF; raddr1_i = 0 in the same and the next cycle -> 0 both times; debug read of x0 returns 0.
- Debug handshake:
  - dbg write x9 = 0x0000_00C3 -> dbg_ack_o high exactly one cycle after the request edge; port 1 reads 0xC3 the following cycle.
  - dbg read x9 -> dbg_rdata_o = 0x0000_00C3 with ack.
- Collision: primary writes x4 = 0x1111_1111 and debug writes x4 = 0x2222_2222 in the same cycle -> x4 = 0x1111_1111 and ack still pulses. A debug write to x6 in the same cycle instead -> both committed.
